// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Purpose  : Serial-to-parallel UART receiver, 8N1 (8E1 with PARITY_EN),
//            LSB first, idle-high line. rx_in is synchronised by two flops and
//            sampled with an internally generated 16x (OVS) oversampling tick.
// Ports    : clk        - system clock, rising edge
//            rst        - synchronous active-high reset
//            rx_in      - asynchronous serial input, idle high
//            rx_data    - last correctly framed byte, held until next good one
//            rx_valid   - 1-clk pulse, rx_data updated
//            rx_status  - high while a frame is in progress
//            frame_err  - 1-clk pulse, stop bit sampled low
//            parity_err - 1-clk pulse, even-parity mismatch (0 without PARITY_EN)
// Config   : define PARITY_EN for 8E1 framing with a parity check.
// Revision : 1.0 - initial release
// ============================================================================
module uart_receiver #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600,
  parameter int OVS    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_status,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int DIV   = CLK_HZ / (BAUD * OVS);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OVS_W = $clog2(OVS);

  localparam logic [DIV_W-1:0] c_div_max  = DIV_W'(DIV - 1);
  localparam logic [OVS_W-1:0] c_ovs_max  = OVS_W'(OVS - 1);
  localparam logic [OVS_W-1:0] c_half_max = OVS_W'(OVS / 2 - 1);

  localparam logic [2:0] c_idle   = 3'd0;
  localparam logic [2:0] c_start  = 3'd1;
  localparam logic [2:0] c_data   = 3'd2;
`ifdef PARITY_EN
  localparam logic [2:0] c_parity = 3'd3;
`endif
  localparam logic [2:0] c_stop   = 3'd4;
  localparam logic [2:0] c_break  = 3'd5;

  logic             r_sync1, r_sync2;
  logic             w_rx;
  logic [DIV_W-1:0] r_div_cnt;
  logic             w_tick;
  logic [2:0]       r_state, w_state_nxt;
  logic [OVS_W-1:0] r_ovs_cnt;
  logic             w_bit_end;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             w_valid_nxt, w_ferr_nxt, w_status_nxt;
`ifdef PARITY_EN
  logic             r_par_bit;
  logic             w_perr_nxt;
`endif

  // Two-flop synchronizer, preset to the idle level so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end
  assign w_rx = r_sync2;

  // Free-running oversampling tick divider
  always_ff @(posedge clk) begin
    if (rst || w_tick) r_div_cnt <= '0;
    else               r_div_cnt <= r_div_cnt + DIV_W'(1);
  end
  assign w_tick = (r_div_cnt == c_div_max);

  // START waits half a bit to land mid start bit; every later state waits a whole bit
  assign w_bit_end = (r_state == c_start) ? (r_ovs_cnt == c_half_max)
                                          : (r_ovs_cnt == c_ovs_max);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_idle;
    else     r_state <= w_state_nxt;
  end

  // FSM: next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_tick) begin
      case (r_state)
        c_idle:  if (!w_rx) w_state_nxt = c_start;
        c_start: if (w_bit_end) w_state_nxt = w_rx ? c_idle : c_data;
        c_data: begin
          if (w_bit_end && (r_bit_idx == 3'd7)) begin
`ifdef PARITY_EN
            w_state_nxt = c_parity;
`else
            w_state_nxt = c_stop;
`endif
          end
        end
`ifdef PARITY_EN
        c_parity: if (w_bit_end) w_state_nxt = c_stop;
`endif
        c_stop:  if (w_bit_end) w_state_nxt = w_rx ? c_idle : c_break;
        c_break: if (w_rx) w_state_nxt = c_idle;
        default: w_state_nxt = c_idle;
      endcase
    end
  end

  // FSM: output decode; results are registered so every pulse is exactly one clk
  always_comb begin
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
`ifdef PARITY_EN
    w_perr_nxt  = 1'b0;
`endif
    if (w_tick && (r_state == c_stop) && w_bit_end) begin
      if (!w_rx) begin
        w_ferr_nxt = 1'b1;
`ifdef PARITY_EN
      end else if (^{r_shift, r_par_bit}) begin
        w_perr_nxt = 1'b1;
`endif
      end else begin
        w_valid_nxt = 1'b1;
      end
    end
    w_status_nxt = (w_state_nxt == c_data) || (w_state_nxt == c_stop)
`ifdef PARITY_EN
                   || (w_state_nxt == c_parity)
`endif
                   ;
  end

  // Bit timing counters and shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovs_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
`ifdef PARITY_EN
      r_par_bit <= 1'b0;
`endif
    end else if (w_tick) begin
      if ((r_state == c_idle) || w_bit_end) r_ovs_cnt <= '0;
      else                                  r_ovs_cnt <= r_ovs_cnt + OVS_W'(1);
      if (r_state == c_start) begin
        r_bit_idx <= '0;
      end else if ((r_state == c_data) && w_bit_end) begin
        r_bit_idx <= r_bit_idx + 3'd1;
        r_shift   <= {w_rx, r_shift[7:1]};
      end
`ifdef PARITY_EN
      if ((r_state == c_parity) && w_bit_end) r_par_bit <= w_rx;
`endif
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_status <= 1'b0;
      frame_err <= 1'b0;
`ifdef PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      rx_valid  <= w_valid_nxt;
      frame_err <= w_ferr_nxt;
      rx_status <= w_status_nxt;
      if (w_valid_nxt) rx_data <= r_shift;
`ifdef PARITY_EN
      parity_err <= w_perr_nxt;
`endif
    end
  end

`ifndef PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
module tb_uart_receiver;

  localparam int CLK_HZ  = 1_600_000;
  localparam int BAUD    = 10_000;
  localparam int OVS     = 16;
  localparam int BIT_CLK = 160;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_status, frame_err, parity_err;

  int checks = 0;
  int errors = 0;

  // kind is one-hot {parity_err, frame_err, rx_valid}
  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] data;
  } exp_t;

  exp_t       q[$];
  logic [7:0] last_good = 8'h00;
  logic       prev_pulse = 1'b0;

  uart_receiver #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVS(OVS)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_status  (rx_status),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  // Monitor: pops one expectation per output pulse and checks pulse width
  always @(negedge clk) begin : monitor
    logic [2:0] act;
    exp_t       e;
    act = {parity_err, frame_err, rx_valid};
    if (prev_pulse) begin
      checks++;
      if (act != 3'b000) begin
        errors++;
        $display("FAIL pulse_width: pulses %b still high second clk, required 000", act);
      end
    end
    if ((act != 3'b000) && !prev_pulse) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: pulses %b data %h, required none", act, rx_data);
      end else begin
        e = q.pop_front();
        checks++;
        if (act != e.kind) begin
          errors++;
          $display("FAIL pulse_kind: got %b, required %b", act, e.kind);
        end
        checks++;
        if (rx_data != e.data) begin
          errors++;
          $display("FAIL rx_data: got %h, required %h", rx_data, e.data);
        end
      end
    end
    prev_pulse = (act != 3'b000);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_valid(input logic [7:0] d);
    q.push_back({3'b001, d});
    last_good = d;
  endtask

  task automatic expect_ferr();
    q.push_back({3'b010, last_good});
  endtask

`ifdef PARITY_EN
  task automatic expect_perr();
    q.push_back({3'b100, last_good});
  endtask
`endif

  task automatic send_frame(input logic [7:0] d, input logic stop_val, input logic par_flip);
    rx_in = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      if (i == 4) begin
        wait_clk(BIT_CLK / 2);
        @(negedge clk);
        chk("rx_status_mid_frame", {7'd0, rx_status}, 8'd1);
        wait_clk(BIT_CLK / 2);
      end else begin
        wait_clk(BIT_CLK);
      end
    end
`ifdef PARITY_EN
    rx_in = (^d) ^ par_flip;
    wait_clk(BIT_CLK);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    rx_in = stop_val;
    wait_clk(BIT_CLK);
    rx_in = 1'b1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_rx_data"}, rx_data, 8'h00);
    chk({name, "_pulses"}, {5'd0, parity_err, frame_err, rx_valid}, 8'h00);
    chk({name, "_rx_status"}, {7'd0, rx_status}, 8'h00);
  endtask

  initial begin
    logic [7:0] b55;
    int         cnt;
    b55 = 8'h55;

    // Reset state
    rst = 1'b1;
    rx_in = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");

    // 1. Single good frame
    expect_valid(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    wait_clk(BIT_CLK);

    // 2. 30-clk glitch on idle line
    rx_in = 1'b0;
    wait_clk(30);
    rx_in = 1'b1;
    wait_clk(2 * BIT_CLK);
    @(negedge clk);
    chk("glitch_rx_status", {7'd0, rx_status}, 8'h00);
    chk("glitch_rx_data", rx_data, 8'hA5);

    // 3. Framing error, then a good frame
    expect_ferr();
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_clk(BIT_CLK);
    @(negedge clk);
    chk("ferr_rx_data_held", rx_data, 8'hA5);
    chk("ferr_rx_status", {7'd0, rx_status}, 8'h00);
    expect_valid(8'h81);
    send_frame(8'h81, 1'b1, 1'b0);
    wait_clk(BIT_CLK);

    // 4. Back-to-back frames with no idle gap
    expect_valid(8'h00);
    expect_valid(8'hFF);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    wait_clk(BIT_CLK);

    // 5. Reset in the middle of bit 4 of 8'h55; line returns to idle
    rx_in = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      rx_in = b55[i];
      wait_clk(BIT_CLK);
    end
    rx_in = b55[4];
    wait_clk(BIT_CLK / 2);
    @(negedge clk);
    chk("pre_reset_rx_status", {7'd0, rx_status}, 8'd1);
    wait_clk(1);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    last_good = 8'h00;
    @(negedge clk);
    chk_all_zero("mid_frame_reset");
    rx_in = 1'b1;
    wait_clk(4 * BIT_CLK);
    expect_valid(8'h12);
    send_frame(8'h12, 1'b1, 1'b0);
    wait_clk(BIT_CLK);

`ifdef PARITY_EN
    // 6. Even parity: correct then flipped parity bit
    expect_valid(8'h03);
    send_frame(8'h03, 1'b1, 1'b0);
    wait_clk(BIT_CLK);
    expect_perr();
    send_frame(8'h03, 1'b1, 1'b1);
    wait_clk(BIT_CLK);
    @(negedge clk);
    chk("perr_rx_data_held", rx_data, 8'h03);
`endif

    // All expected pulses must have been seen, bounded wait
    cnt = 0;
    while ((q.size() != 0) && (cnt < 2000)) begin
      wait_clk(1);
      cnt++;
    end
    chk("scoreboard_drained", 8'(q.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
